renode_ahb_subordinate_mem: RTL

RENODE_AHB_SUBORDINATE_MEM -- requirements
Module: renode_ahb_subordinate_mem

---
 rtl/renode_ahb_subordinate_mem_if.sv | 28 ++
 rtl/renode_ahb_subordinate_mem.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/renode_ahb_subordinate_mem_if.sv
// AHB-Lite subordinate bus bundle: address/data phase signals from the master
// and the response signals returned by the subordinate.
interface renode_ahb_subordinate_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/renode_ahb_subordinate_mem.sv
// AHB-Lite memory subordinate: byte-lane RAM with optional wait states,
// two-cycle ERROR response and write-to-read forwarding for pipelined access.
module renode_ahb_subordinate_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic HCLK,
    input  logic HRESETn,
    renode_ahb_subordinate_mem_if.slave ahb
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH+1:0] MEM_BYTES = (ADDR_WIDTH + 2)'(4 * MEM_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t           state_reg;
    logic [3:0]       wait_cnt_reg;
    logic             hreadyout_reg;
    logic             hresp_reg;
    logic             dp_active_reg;
    logic             dp_write_reg;
    logic [IDX_W-1:0] dp_idx_reg;
    logic [3:0]       dp_lanes_reg;

    logic             accept;
    logic             req_err;
    logic [3:0]       req_lanes;
    logic [IDX_W-1:0] req_idx;
    logic             mem_we;
    logic             mem_re;
    logic [DATA_WIDTH-1:0] rd_word;
    logic             unused_inputs;

    assign unused_inputs = ^{ahb.HBURST, ahb.HTRANS[0]};

    // Only a state that is presenting HREADYOUT=1 can take a new address phase.
    assign accept  = hreadyout_reg && ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY;
    assign req_idx = ahb.HADDR[IDX_W+1:2];

    always_comb begin
        req_err   = 1'b0;
        req_lanes = 4'b1111;
        case (ahb.HSIZE)
            3'd0: req_lanes = 4'b0001 << ahb.HADDR[1:0];
            3'd1: begin
                req_lanes = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
                req_err   = ahb.HADDR[0];
            end
            3'd2: req_err = (ahb.HADDR[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if ({2'b00, ahb.HADDR} >= MEM_BYTES) begin
            req_err = 1'b1;
        end
    end

    // The edge that ends an OKAY data phase is the one where HREADYOUT is high.
    assign mem_we = dp_active_reg && dp_write_reg && hreadyout_reg;
    assign mem_re = accept && !req_err && !ahb.HWRITE;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 4'd0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
            dp_active_reg <= 1'b0;
            dp_write_reg  <= 1'b0;
            dp_idx_reg    <= '0;
            dp_lanes_reg  <= 4'b0000;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (wait_cnt_reg <= 4'd1) begin
                        state_reg     <= ST_IDLE;
                        wait_cnt_reg  <= 4'd0;
                        hreadyout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b0;
                    dp_active_reg <= 1'b0;
                    if (accept) begin
                        if (req_err) begin
                            state_reg     <= ST_ERR1;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= 1'b1;
                        end else begin
                            dp_active_reg <= 1'b1;
                            dp_write_reg  <= ahb.HWRITE;
                            dp_idx_reg    <= req_idx;
                            dp_lanes_reg  <= req_lanes;
                            if (WAIT_STATES > 0) begin
                                state_reg     <= ST_WAIT;
                                wait_cnt_reg  <= 4'(WAIT_STATES);
                                hreadyout_reg <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // One RAM per byte lane; a read accepted on the same edge as a write to the
    // same word takes the fresh bytes straight from HWDATA.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [MEM_WORDS];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge HCLK) begin
            if (mem_we && dp_lanes_reg[gi]) begin
                mem[dp_idx_reg] <= ahb.HWDATA[8*gi +: 8];
            end
            if (mem_re) begin
                if (mem_we && dp_lanes_reg[gi] && (dp_idx_reg == req_idx)) begin
                    rd_byte_reg <= ahb.HWDATA[8*gi +: 8];
                end else begin
                    rd_byte_reg <= mem[req_idx];
                end
            end
        end

        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    assign ahb.HREADYOUT = hreadyout_reg;
    assign ahb.HRESP     = hresp_reg;
    assign ahb.HRDATA    = (dp_active_reg && !dp_write_reg && hreadyout_reg) ? rd_word : '0;
endmodule
